// File: rtl/rggen_apb_register_access.sv
// APB4 completer bridging one APB transfer to one register-side access.
// Three-state controller: IDLE -> ACCESS -> RESPOND, with optional access timeout.
module rggen_apb_register_access #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic                     i_pwrite,
  input  logic [DATA_WIDTH-1:0]    i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]  i_pstrb,
  output logic                     o_pready,
  output logic [DATA_WIDTH-1:0]    o_prdata,
  output logic                     o_pslverr,
  output logic                     o_reg_valid,
  output logic                     o_reg_write,
  output logic [ADDRESS_WIDTH-1:0] o_reg_address,
  output logic [DATA_WIDTH-1:0]    o_reg_write_data,
  output logic [DATA_WIDTH-1:0]    o_reg_write_mask,
  input  logic                     i_reg_ready,
  input  logic [DATA_WIDTH-1:0]    i_reg_read_data,
  input  logic                     i_reg_error
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     write_q, write_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    mask_q, mask_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     error_q, error_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    strb_mask;
  logic                     timeout_hit;

  // Expand byte strobes into a per-bit write enable.
  for (genvar b = 0; b < STRB_W; b++) begin : g_strb
    assign strb_mask[b*8 +: 8] = {8{i_pstrb[b]}};
  end

  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    error_d = error_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_psel && !i_penable) begin
          addr_d  = i_paddr;
          write_d = i_pwrite;
          wdata_d = i_pwrite ? i_pwdata : '0;
          mask_d  = i_pwrite ? strb_mask : '1;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (i_reg_ready) begin
          rdata_d = write_q ? '0 : i_reg_read_data;
          error_d = i_reg_error;
          state_d = RESPOND;
        end else if (timeout_hit) begin
          rdata_d = '0;
          error_d = 1'b1;
          state_d = RESPOND;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_reg_valid      = (state_q == ACCESS);
  assign o_reg_write      = write_q;
  assign o_reg_address    = addr_q;
  assign o_reg_write_data = wdata_q;
  assign o_reg_write_mask = mask_q;
  assign o_pready         = (state_q == RESPOND);
  assign o_prdata         = (state_q == RESPOND) ? rdata_q : '0;
  assign o_pslverr        = (state_q == RESPOND) && error_q;

endmodule

// File: tb/tb_rggen_apb_register_access.sv
// Directed bench for rggen_apb_register_access: one instance without timeout,
// one with TIMEOUT=4; APB select is steered to whichever instance a vector targets.
module tb_rggen_apb_register_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        reg_ready, reg_err;
  logic [31:0] reg_rdata;
  bit          sel4;

  logic        pready0, pslverr0, valid0, write0;
  logic [31:0] prdata0, wdata0, mask0;
  logic [15:0] addr0;
  logic        pready4, pslverr4, valid4, write4;
  logic [31:0] prdata4, wdata4, mask4;
  logic [15:0] addr4;

  logic        m_pready, m_pslverr, m_valid, m_write;
  logic [31:0] m_prdata, m_wdata, m_mask;
  logic [15:0] m_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rggen_apb_register_access #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel && !sel4), .i_penable(penable),
    .i_paddr(paddr), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready0), .o_prdata(prdata0), .o_pslverr(pslverr0),
    .o_reg_valid(valid0), .o_reg_write(write0), .o_reg_address(addr0),
    .o_reg_write_data(wdata0), .o_reg_write_mask(mask0),
    .i_reg_ready(reg_ready), .i_reg_read_data(reg_rdata), .i_reg_error(reg_err)
  );

  rggen_apb_register_access #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel && sel4), .i_penable(penable),
    .i_paddr(paddr), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready4), .o_prdata(prdata4), .o_pslverr(pslverr4),
    .o_reg_valid(valid4), .o_reg_write(write4), .o_reg_address(addr4),
    .o_reg_write_data(wdata4), .o_reg_write_mask(mask4),
    .i_reg_ready(reg_ready), .i_reg_read_data(reg_rdata), .i_reg_error(reg_err)
  );

  assign m_pready  = sel4 ? pready4  : pready0;
  assign m_pslverr = sel4 ? pslverr4 : pslverr0;
  assign m_valid   = sel4 ? valid4   : valid0;
  assign m_write   = sel4 ? write4   : write0;
  assign m_prdata  = sel4 ? prdata4  : prdata0;
  assign m_wdata   = sel4 ? wdata4   : wdata0;
  assign m_mask    = sel4 ? mask4    : mask0;
  assign m_addr    = sel4 ? addr4    : addr0;

  typedef struct {
    bit          sel4;
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ready_at;   // ACCESS cycle index at which ready is given; -1 = never
    logic [31:0] rdata;
    bit          err;
    logic [31:0] exp_mask;
    logic [31:0] exp_wdata;
    int          exp_valid;  // cycles of o_reg_valid, also pready latency from T1
    logic [31:0] exp_prdata;
    bit          exp_err;
    bit          b2b;        // start without an idle cycle after the previous transfer
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts in an idle cycle at posedge+1, ends in the idle cycle after RESPOND.
  task automatic xfer(input vec_t v);
    int c;
    int n_valid;
    bit done;
    sel4    = v.sel4;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = v.wr;
    paddr   = v.addr;
    pwdata  = v.wdata;
    pstrb   = v.strb;
    reg_ready = 1'b0; reg_err = 1'b0; reg_rdata = '0;
    @(posedge clk); #1;
    penable = 1'b1;
    c = 0; n_valid = 0; done = 1'b0;
    while (!done && c < 40) begin
      if (m_pready) begin
        done = 1'b1;
        chk("latency", c, v.exp_valid);
        chk("prdata", m_prdata, v.exp_prdata);
        chk("pslverr", m_pslverr, v.exp_err);
        chk("valid_in_respond", m_valid, 1'b0);
      end else begin
        if (m_valid) n_valid++;
        if (c == 0) begin
          chk("valid_t1", m_valid, 1'b1);
          chk("address", m_addr, v.addr);
          chk("write", m_write, v.wr);
          chk("write_data", m_wdata, v.exp_wdata);
          chk("write_mask", m_mask, v.exp_mask);
          chk("prdata_access", m_prdata, 32'h0);
        end
        if (c == v.ready_at) begin
          reg_ready = 1'b1; reg_rdata = v.rdata; reg_err = v.err;
        end
        @(posedge clk); #1;
        reg_ready = 1'b0; reg_rdata = '0; reg_err = 1'b0;
        c++;
      end
    end
    chk("pready_seen", done, 1'b1);
    chk("valid_cycles", n_valid, v.exp_valid);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    chk("pready_after", m_pready, 1'b0);
    chk("prdata_after", m_prdata, 32'h0);
    chk("pslverr_after", m_pslverr, 1'b0);
    chk("valid_after", m_valid, 1'b0);
  endtask

  initial begin
    //            sel4 wr addr      wdata         strb     rdy rdata         err mask          wdata_exp     nv prdata_exp    eerr b2b
    vecs[0] = '{0, 1, 16'h1234, 32'hA5A5_5A5A, 4'b0101,  0, 32'hFFFF_FFFF, 0, 32'h00FF_00FF, 32'hA5A5_5A5A, 1, 32'h0000_0000, 0, 0};
    vecs[1] = '{0, 0, 16'h0010, 32'h1111_2222, 4'b1111,  3, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 32'h0000_0000, 4, 32'hDEAD_BEEF, 0, 0};
    vecs[2] = '{0, 1, 16'h0004, 32'h0BAD_CAFE, 4'b1010,  1, 32'h0000_0000, 1, 32'hFF00_FF00, 32'h0BAD_CAFE, 2, 32'h0000_0000, 1, 0};
    vecs[3] = '{0, 0, 16'h0008, 32'h0000_0000, 4'b0000,  0, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF, 32'h0000_0000, 1, 32'h0BAD_F00D, 0, 1};
    vecs[4] = '{0, 1, 16'h0003, 32'h1234_5678, 4'b1111,  0, 32'h0000_0000, 0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 32'h0000_0000, 0, 1};
    vecs[5] = '{0, 0, 16'hFFFC, 32'h0000_0000, 4'b0000,  7, 32'h8000_0001, 0, 32'hFFFF_FFFF, 32'h0000_0000, 8, 32'h8000_0001, 0, 0};
    vecs[6] = '{1, 0, 16'h0020, 32'h0000_0000, 4'b0000, -1, 32'h7777_7777, 0, 32'hFFFF_FFFF, 32'h0000_0000, 4, 32'h0000_0000, 1, 0};
    vecs[7] = '{1, 0, 16'h0024, 32'h0000_0000, 4'b0000,  3, 32'h5555_AAAA, 0, 32'hFFFF_FFFF, 32'h0000_0000, 4, 32'h5555_AAAA, 0, 0};
    vecs[8] = '{1, 1, 16'h0028, 32'hCAFE_0001, 4'b0011, -1, 32'h0000_0000, 0, 32'h0000_FFFF, 32'hCAFE_0001, 4, 32'h0000_0000, 1, 0};

    rst_n = 1'b0; sel4 = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    reg_ready = 1'b0; reg_err = 1'b0; reg_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", pready0, 1'b0);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_prdata", prdata0, 32'h0);
    chk("rst_address", addr0, 16'h0);
    chk("rst_mask", mask0, 32'h0);
    chk("rst_valid4", valid4, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      if (!vecs[i].b2b) begin
        @(posedge clk); #1;
      end
      xfer(vecs[i]);
    end

    // Reset in the middle of an access abandons it immediately.
    @(posedge clk); #1;
    sel4 = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 16'h0ABC; pwdata = 32'h0F0F_0F0F; pstrb = 4'b1111;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("pre_rst_valid", valid0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", valid0, 1'b0);
    chk("midrst_write", write0, 1'b0);
    chk("midrst_address", addr0, 16'h0);
    chk("midrst_wdata", wdata0, 32'h0);
    chk("midrst_mask", mask0, 32'h0);
    chk("midrst_pready", pready0, 1'b0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
